// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, reset defaults and field positions for the multi-compare timer
package timer_pkg;

    localparam int MAX_DIV = 8;
    localparam int MAX_CH  = 8;

    localparam logic [11:0] ADDR_TCR      = 12'h000;
    localparam logic [11:0] ADDR_TDR0     = 12'h004;
    localparam logic [11:0] ADDR_TDR1     = 12'h008;
    localparam logic [11:0] ADDR_TIER     = 12'h00C;
    localparam logic [11:0] ADDR_TISR     = 12'h010;
    localparam logic [11:0] ADDR_THCSR    = 12'h014;
    localparam logic [11:0] ADDR_CMP_BASE = 12'h100;

    localparam logic [31:0] TCR_RESET  = 32'h0000_0100;
    localparam logic [63:0] TCMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int TCR_EN_BIT     = 0;
    localparam int TCR_DIV_EN_BIT = 1;
    localparam int TCR_DIV_LSB    = 8;
    localparam int TCR_DIV_MSB    = 11;
    localparam int THCSR_REQ_BIT  = 0;
    localparam int THCSR_ACK_BIT  = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TCR,
        SEL_TDR0,
        SEL_TDR1,
        SEL_TIER,
        SEL_TISR,
        SEL_THCSR,
        SEL_CMP
    } reg_sel_e;

    function automatic logic div_legal(input logic [3:0] v);
        return int'(v) <= MAX_DIV;
    endfunction

endpackage

// File: rtl/timer_multi_cmp_if.sv
// rtl/timer_multi_cmp_if.sv - register access bus for the multi-compare timer
interface timer_multi_cmp_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, err);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, err);
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - power-of-two tick divider with clear and halt freeze
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       div_en,
    input  logic [3:0] div_val,
    input  logic       clear,
    input  logic       halt,
    output logic       tick
);
    logic [MAX_DIV-1:0] cnt;
    logic [MAX_DIV:0]   limit;
    logic               running;

    assign limit   = ({{MAX_DIV{1'b0}}, 1'b1} << div_val) - {{MAX_DIV{1'b0}}, 1'b1};
    assign running = enable && !halt;
    assign tick    = running && (!div_en || ({1'b0, cnt} == limit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (running && div_en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/timer_multi_cmp.sv
// rtl/timer_multi_cmp.sv - 64-bit free-running timer with per-channel compare interrupts
module timer_multi_cmp
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_multi_cmp_if.slave  bus,
    input  logic              debug_halt,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);
    localparam logic [ADDR_WIDTH-1:0] CMP_BASE_A = ADDR_WIDTH'(ADDR_CMP_BASE);

    wire [ADDR_WIDTH-1:0] addr = bus.addr;
    wire [31:0]           w    = bus.wdata[31:0];

    reg_sel_e    sel;
    logic [2:0]  ch_idx;
    logic        ch_hi, cmp_region;
    logic        div_ok, tcr_wr, wr_ok, presc_clear, tick, halt_ack;
    logic        timer_en, div_en, halt_req;
    logic [3:0]  div_val;
    logic [63:0] cnt;
    logic [31:0] shadow, rd_word;
    logic [NUM_CH-1:0] tier, tisr;
    logic [31:0] cmp_lo_rd [MAX_CH];
    logic [31:0] cmp_hi_rd [MAX_CH];

    assign ch_idx     = addr[5:3];
    assign ch_hi      = addr[2];
    assign cmp_region = (addr[ADDR_WIDTH-1:6] == CMP_BASE_A[ADDR_WIDTH-1:6]) &&
                        (addr[1:0] == 2'b00) && (int'(ch_idx) < NUM_CH);

    always_comb begin
        sel = SEL_NONE;
        case (addr)
            ADDR_WIDTH'(ADDR_TCR):   sel = SEL_TCR;
            ADDR_WIDTH'(ADDR_TDR0):  sel = SEL_TDR0;
            ADDR_WIDTH'(ADDR_TDR1):  sel = SEL_TDR1;
            ADDR_WIDTH'(ADDR_TIER):  sel = SEL_TIER;
            ADDR_WIDTH'(ADDR_TISR):  sel = SEL_TISR;
            ADDR_WIDTH'(ADDR_THCSR): sel = SEL_THCSR;
            default:                 if (cmp_region) sel = SEL_CMP;
        endcase
    end

    // An out-of-range divider rejects the whole TCR write, not just the field.
    assign div_ok   = div_legal(w[TCR_DIV_MSB:TCR_DIV_LSB]);
    assign tcr_wr   = bus.wr_en && (sel == SEL_TCR);
    assign wr_ok    = bus.wr_en && (sel != SEL_NONE) && !(tcr_wr && !div_ok);
    assign bus.err  = ((bus.rd_en || bus.wr_en) && (sel == SEL_NONE)) || (tcr_wr && !div_ok);
    assign halt_ack = halt_req && debug_halt;

    assign presc_clear = (tcr_wr && div_ok &&
                          ((w[TCR_DIV_EN_BIT] != div_en) || (w[TCR_DIV_MSB:TCR_DIV_LSB] != div_val))) ||
                         (wr_ok && ((sel == SEL_TDR0) || (sel == SEL_TDR1)));

    timer_prescaler u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (timer_en),
        .div_en  (div_en),
        .div_val (div_val),
        .clear   (presc_clear),
        .halt    (halt_ack),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en <= TCR_RESET[TCR_EN_BIT];
            div_en   <= TCR_RESET[TCR_DIV_EN_BIT];
            div_val  <= TCR_RESET[TCR_DIV_MSB:TCR_DIV_LSB];
            tier     <= '0;
            halt_req <= 1'b0;
            shadow   <= '0;
            cnt      <= '0;
        end else begin
            if (wr_ok && sel == SEL_TCR) begin
                timer_en <= w[TCR_EN_BIT];
                div_en   <= w[TCR_DIV_EN_BIT];
                div_val  <= w[TCR_DIV_MSB:TCR_DIV_LSB];
            end
            if (wr_ok && sel == SEL_TIER)  tier     <= w[NUM_CH-1:0];
            if (wr_ok && sel == SEL_THCSR) halt_req <= w[THCSR_REQ_BIT];
            // Latching the high half on the low-half read makes a 64-bit read atomic.
            if (bus.rd_en && sel == SEL_TDR0) shadow <= cnt[63:32];
            if (wr_ok && sel == SEL_TDR0)      cnt[31:0]  <= w;
            else if (wr_ok && sel == SEL_TDR1) cnt[63:32] <= w;
            else if (tick)                     cnt        <= cnt + 64'd1;
        end
    end

    for (genvar n = 0; n < MAX_CH; n++) begin : g_ch
        if (n < NUM_CH) begin : g_used
            logic [63:0] cmp_q;
            logic        tisr_q, irq_q, hit, sel_me;

            assign sel_me = wr_ok && (sel == SEL_CMP) && (ch_idx == 3'(n));
            assign hit    = (cnt >= cmp_q);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmp_q  <= TCMP_RESET;
                    tisr_q <= 1'b0;
                    irq_q  <= 1'b0;
                end else begin
                    if (sel_me && ch_hi)  cmp_q[63:32] <= w;
                    if (sel_me && !ch_hi) cmp_q[31:0]  <= w;
                    if (hit)                                     tisr_q <= 1'b1;
                    else if (wr_ok && sel == SEL_TISR && w[n])   tisr_q <= 1'b0;
                    irq_q <= tisr_q && tier[n];
                end
            end

            assign cmp_lo_rd[n] = cmp_q[31:0];
            assign cmp_hi_rd[n] = cmp_q[63:32];
            assign tisr[n]      = tisr_q;
            assign irq[n]       = irq_q;
        end else begin : g_unused
            assign cmp_lo_rd[n] = '0;
            assign cmp_hi_rd[n] = '0;
        end
    end

    assign irq_any = |irq;

    always_comb begin
        rd_word = '0;
        if (bus.rd_en) begin
            case (sel)
                SEL_TCR:   rd_word = {20'd0, div_val, 6'd0, div_en, timer_en};
                SEL_TDR0:  rd_word = cnt[31:0];
                SEL_TDR1:  rd_word = shadow;
                SEL_TIER:  rd_word = 32'(tier);
                SEL_TISR:  rd_word = 32'(tisr);
                SEL_THCSR: rd_word = {30'd0, halt_ack, halt_req};
                SEL_CMP:   rd_word = ch_hi ? cmp_hi_rd[ch_idx] : cmp_lo_rd[ch_idx];
                default:   rd_word = '0;
            endcase
        end
    end

    assign bus.rdata = DATA_WIDTH'(rd_word);
endmodule

// File: tb/tb_timer_multi_cmp.sv
// tb/tb_timer_multi_cmp.sv - scoreboard bench for the multi-compare timer
module tb_timer_multi_cmp;
    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              debug_halt = 1'b0;
    logic              probe = 1'b0;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    timer_multi_cmp_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    timer_multi_cmp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .debug_halt (debug_halt),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        e;
        int          kind;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // kind 0: read (rdata+err), 1: write (err), 2: irq probe ({irq_any, irq})
    always @(negedge clk) begin
        exp_t        x;
        logic [31:0] act;
        if (bus.rd_en || bus.wr_en || probe) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL no_expectation: DUT access with empty scoreboard");
            end else begin
                x = sb.pop_front();
                if (x.kind == 0) begin
                    if (bus.rdata !== x.d || bus.err !== x.e) begin
                        n_bad++;
                        $display("FAIL %s: rdata=0x%08h err=%0b, expected rdata=0x%08h err=%0b",
                                 x.nm, bus.rdata, bus.err, x.d, x.e);
                    end
                end else if (x.kind == 1) begin
                    if (bus.err !== x.e) begin
                        n_bad++;
                        $display("FAIL %s: err=%0b, expected err=%0b", x.nm, bus.err, x.e);
                    end
                end else begin
                    act = {27'd0, irq_any, irq};
                    if (act !== x.d) begin
                        n_bad++;
                        $display("FAIL %s: {irq_any,irq}=0x%02h, expected 0x%02h", x.nm, act, x.d);
                    end
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] d, input logic e, input int kind);
        exp_t x;
        x.nm = nm; x.d = d; x.e = e; x.kind = kind;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic e, input string nm);
        push_exp(nm, 32'd0, e, 1);
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic e, input string nm);
        push_exp(nm, d, e, 0);
        bus.addr = a; bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_irq(input logic [31:0] d, input string nm);
        push_exp(nm, d, 1'b0, 2);
        probe = 1'b1;
        cyc();
        probe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // reset state and decode boundaries
        rd(12'h000, 32'h0000_0100, 1'b0, "rst_tcr");
        rd(12'h004, 32'h0, 1'b0, "rst_tdr0");
        rd(12'h008, 32'h0, 1'b0, "rst_tdr1");
        rd(12'h00C, 32'h0, 1'b0, "rst_tier");
        rd(12'h010, 32'h0, 1'b0, "rst_tisr");
        rd(12'h014, 32'h0, 1'b0, "rst_thcsr");
        rd(12'h100, 32'hFFFF_FFFF, 1'b0, "rst_tcmp0_lo");
        rd(12'h104, 32'hFFFF_FFFF, 1'b0, "rst_tcmp0_hi");
        rd(12'h11C, 32'hFFFF_FFFF, 1'b0, "rst_tcmp3_hi");
        chk_irq(32'h00, "rst_irq");
        rd(12'h120, 32'h0, 1'b1, "rd_tcmp4_unmapped");
        rd(12'h018, 32'h0, 1'b1, "rd_018_unmapped");
        wr(12'h120, 32'h1234_5678, 1'b1, "wr_tcmp4_unmapped");
        rd(12'h100, 32'hFFFF_FFFF, 1'b0, "tcmp0_not_aliased");

        // compare channel 0 at 0x10, interrupt one cycle after TISR
        wr(12'h100, 32'h10, 1'b0, "wr_tcmp0_lo");
        wr(12'h104, 32'h0, 1'b0, "wr_tcmp0_hi");
        wr(12'h00C, 32'h1, 1'b0, "wr_tier");
        wr(12'h000, 32'h1, 1'b0, "wr_tcr_run");
        idle(15);
        rd(12'h010, 32'h0, 1'b0, "tisr_cnt_0f");
        rd(12'h010, 32'h0, 1'b0, "tisr_cnt_10");
        rd(12'h010, 32'h1, 1'b0, "tisr_set");
        chk_irq(32'h11, "irq0_set");
        rd(12'h004, 32'h13, 1'b0, "cnt_0x13");
        wr(12'h000, 32'h0, 1'b0, "wr_tcr_stop");
        rd(12'h004, 32'h15, 1'b0, "cnt_stopped");
        rd(12'h00C, 32'h1, 1'b0, "tier_rb");

        // clear versus held compare
        wr(12'h010, 32'h1, 1'b0, "w1c_while_hit");
        rd(12'h010, 32'h1, 1'b0, "tisr_set_wins");
        wr(12'h104, 32'h1, 1'b0, "raise_tcmp0");
        wr(12'h010, 32'h1, 1'b0, "w1c_clear");
        rd(12'h010, 32'h0, 1'b0, "tisr_cleared");
        chk_irq(32'h00, "irq0_cleared");

        // divide by 4 and rejected divider
        wr(12'h004, 32'h0, 1'b0, "wr_tdr0_zero");
        wr(12'h008, 32'h0, 1'b0, "wr_tdr1_zero");
        wr(12'h000, 32'h203, 1'b0, "wr_tcr_div4");
        rd(12'h004, 32'h0, 1'b0, "div4_c0");
        idle(2);
        rd(12'h004, 32'h0, 1'b0, "div4_c3");
        rd(12'h004, 32'h1, 1'b0, "div4_c4");
        idle(2);
        rd(12'h004, 32'h1, 1'b0, "div4_c7");
        rd(12'h004, 32'h2, 1'b0, "div4_c8");
        wr(12'h000, 32'h903, 1'b1, "wr_tcr_div9");
        rd(12'h000, 32'h203, 1'b0, "tcr_kept");
        rd(12'h004, 32'h2, 1'b0, "cnt_after_bad_tcr");
        wr(12'h000, 32'h0, 1'b0, "wr_tcr_stop2");

        // wrap and atomic 64-bit read
        wr(12'h004, 32'hFFFF_FFFE, 1'b0, "wr_tdr0_fe");
        wr(12'h008, 32'hFFFF_FFFF, 1'b0, "wr_tdr1_ff");
        wr(12'h000, 32'h1, 1'b0, "wr_tcr_run2");
        rd(12'h004, 32'hFFFF_FFFE, 1'b0, "wrap_lo_fe");
        rd(12'h004, 32'hFFFF_FFFF, 1'b0, "wrap_lo_ff");
        rd(12'h008, 32'hFFFF_FFFF, 1'b0, "shadow_atomic");
        rd(12'h004, 32'h1, 1'b0, "wrapped_lo_1");
        rd(12'h008, 32'h0, 1'b0, "wrapped_hi_0");

        // debug halt for 10 cycles
        wr(12'h014, 32'h1, 1'b0, "wr_halt_req");
        debug_halt = 1'b1;
        rd(12'h014, 32'h3, 1'b0, "halt_ack");
        rd(12'h004, 32'h4, 1'b0, "halt_frozen_a");
        idle(6);
        rd(12'h004, 32'h4, 1'b0, "halt_frozen_b");
        rd(12'h014, 32'h3, 1'b0, "halt_ack_end");
        debug_halt = 1'b0;
        rd(12'h004, 32'h4, 1'b0, "resume_first");
        rd(12'h004, 32'h5, 1'b0, "resume_tick");
        rd(12'h014, 32'h1, 1'b0, "halt_released");
        wr(12'h014, 32'h0, 1'b0, "wr_halt_off");

        // reset while counting with an active interrupt
        wr(12'h010, 32'hF, 1'b0, "tisr_clear_all");
        wr(12'h10C, 32'h0, 1'b0, "wr_tcmp1_hi");
        wr(12'h108, 32'h0, 1'b0, "wr_tcmp1_lo");
        wr(12'h00C, 32'h3, 1'b0, "wr_tier_3");
        idle(1);
        chk_irq(32'h12, "irq1_pre_reset");
        rst_n = 1'b0;
        chk_irq(32'h00, "irq_in_reset");
        idle(1);
        rst_n = 1'b1;
        rd(12'h000, 32'h0000_0100, 1'b0, "post_tcr");
        rd(12'h004, 32'h0, 1'b0, "post_tdr0");
        rd(12'h008, 32'h0, 1'b0, "post_tdr1");
        rd(12'h00C, 32'h0, 1'b0, "post_tier");
        rd(12'h010, 32'h0, 1'b0, "post_tisr");
        rd(12'h014, 32'h0, 1'b0, "post_thcsr");
        rd(12'h108, 32'hFFFF_FFFF, 1'b0, "post_tcmp1_lo");
        chk_irq(32'h00, "post_irq");

        idle(2);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
